baud_tick_gen: RTL and testbench
================================

# baud_tick_gen

Programmable fractional baud/oversample tick generator for the UART datapath. It replaces the fixed-divisor generator with one divisor that is both elaboration-time defaulted and runtime-loadable. The divisor has an integer part and a fractional part, and the fractional part is spread over ticks by an accumulator. From the one oversample tick it derives a bit-period tick and a mid-bit sample tick, and it feeds both the UART TX and RX blocks.

## Interface
- CLK — default 100 — system clock frequency in MHz.
- BAUD — default 250000 — default baud rate.
- OVS — default 16 — oversample ticks per bit; power of two, range 4..64.
- DIV_W — default 16 — width of the integer divisor.
- FRAC_W — default 4 — width of the fractional divisor.
- Derived constant DEF_INT = (CLK*10**6)/(BAUD*OVS), using integer division.
- Derived constant DEF_FRAC = ((CLK*10**6*2**FRAC_W)/(BAUD*OVS)) mod 2**FRAC_W.
- CLK*10**6*2**FRAC_W must fit in 31 bits.

Ports:
- i_clk — in — 1 — system clock. Everything is on the rising edge.
- i_rst_n — in — 1 — asynchronous, active-low reset.
- i_en — in — 1 — count enable.
- i_clr — in — 1 — synchronous restart of the count, accumulator and phase.
- i_div_wr — in — 1 — single-cycle divisor write strobe.
- i_div_int — in — DIV_W — integer divisor to load.
- i_div_frac — in — FRAC_W — fractional divisor to load.
- o_div_busy — out — 1 — a written divisor is pending and not yet active.
- o_div_err — out — 1 — one-cycle pulse when a write is rejected.
- o_tick — out — 1 — oversample tick, one cycle wide.
- o_bit_tick — out — 1 — tick at the end of each bit.
- o_mid_tick — out — 1 — tick at the mid-bit sample point.
- o_phase — out — clog2(OVS) — current oversample phase.

## Operation
- State registers:
  - cnt (DIV_W bits), the cycle counter.
  - acc (FRAC_W bits), the fractional accumulator.
  - phase (clog2(OVS) bits), the oversample phase.
  - act_int/act_frac, the active divisor.
  - pend_int/pend_frac plus a pend flag, the pending divisor.
- Reset values:
  - cnt=0, acc=0, phase=0.
  - act = DEF_INT/DEF_FRAC.
  - pend flag = 0.
  - All outputs 0.
- carry = (acc + act_frac) >= 2**FRAC_W. This is combinational, computed with an (FRAC_W+1)-bit sum.
- Interval length = act_int + carry cycles.
- Each enabled edge, non-terminal case (cnt != act_int - 1 + carry):
  - cnt <= cnt+1.
  - o_tick <= 0.
- Each enabled edge, terminal case (cnt == act_int - 1 + carry):
  - cnt <= 0.
  - o_tick <= 1.
  - acc <= (acc + act_frac) mod 2**FRAC_W.
  - phase <= phase+1, wrapping at OVS.
  - If pend is set: act <= pend and pend <= 0.
- o_bit_tick and o_mid_tick are registered alongside o_tick, from the pre-increment phase value:
  - o_bit_tick <= terminal && phase == OVS-1.
  - o_mid_tick <= terminal && phase == OVS/2-1.
- o_phase = phase register.
- i_en=0:
  - cnt, acc and phase hold.
  - All tick outputs are 0 the next cycle.
  - A pending divisor becomes active on the next edge.
- i_clr=1 (takes priority over i_en):
  - cnt, acc and phase go to 0.
  - Tick outputs go to 0.
  - A pending divisor becomes active.
- Divisor write:
  - When i_div_wr=1 and i_div_int >= 2: pend <= {i_div_int, i_div_frac} and the pend flag is set.
  - A write while pend is set overwrites the pending value (last write wins).
  - When i_div_int < 2: the write is ignored and o_div_err pulses the next cycle.
  - o_div_busy = pend flag.
  - A write on the same edge as a terminal count or clear goes to pend. It activates at the next boundary, or next cycle if i_en=0.
- The active divisor never changes mid-interval, so no tick is shortened or glitched.

## Timing
- o_tick/o_bit_tick/o_mid_tick are registered. Each is exactly 1 cycle wide, with no combinational path from inputs.
- First tick: with i_en=1 from reset release, o_tick is high after the (act_int+carry)-th rising edge.
- Steady state: spacing between ticks is act_int or act_int+1 cycles.
- Over 2**FRAC_W ticks the total is exactly act_int*2**FRAC_W + act_frac cycles.
- Minimum interval is 2 cycles, so o_tick is never high on consecutive cycles.
- o_bit_tick coincides with every OVS-th o_tick; o_mid_tick lags it by OVS/2 ticks.
- o_div_busy:
  - Rises the cycle after an accepted write.
  - Falls the cycle after the divisor becomes active.
- Asserting i_rst_n low mid-interval asynchronously forces all registers and outputs to their reset values. Any pending write is lost.

## Test plan
- Defaults CLK=100, BAUD=250000, OVS=16 (DEF_INT=25, DEF_FRAC=0), i_en=1 from reset:
  - o_tick every 25 cycles, first tick after edge 25.
  - o_bit_tick every 400 cycles.
  - o_mid_tick 200 cycles after each o_bit_tick.
- Runtime write int=54, frac=4 (115200 baud):
  - Over 16 ticks the spacings are twelve of 54 and four of 55, total 868 cycles.
  - Every 4th interval is 55 cycles.
- Write while mid-interval:
  - The current interval completes at its old length and the next uses the new divisor.
  - o_div_busy is high until the switch.
  - A second write before the boundary wins.
- Write int=1:
  - o_div_err pulses 1 cycle, o_div_busy stays 0, tick spacing is unchanged.
  - Then write int=2, frac=0: o_tick every 2 cycles, never 2 cycles in a row.
- i_en=0 for 10 cycles mid-interval:
  - No ticks, o_phase holds.
  - After re-enable the interval completes with the remaining count, i.e. total enabled cycles = period.
  - i_clr pulse: the next tick arrives after a full period, with o_phase=0 on the clear.
- i_rst_n asserted low asynchronously mid-interval (not on a clock edge):
  - All outputs drop to 0 immediately, and a pending divisor is discarded.
  - After release, spacing is DEF_INT.

Source files
------------

// File: rtl/baud_tick_gen.sv
// Fractional baud/oversample tick generator: a runtime-loadable int.frac divisor
// drives an oversample tick, and bit-end and mid-bit ticks are derived from it.
module baud_tick_gen #(
    parameter int unsigned CLK    = 100,
    parameter int unsigned BAUD   = 250000,
    parameter int unsigned OVS    = 16,
    parameter int unsigned DIV_W  = 16,
    parameter int unsigned FRAC_W = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_en,
    input  logic                     i_clr,
    input  logic                     i_div_wr,
    input  logic [DIV_W-1:0]         i_div_int,
    input  logic [FRAC_W-1:0]        i_div_frac,
    output logic                     o_div_busy,
    output logic                     o_div_err,
    output logic                     o_tick,
    output logic                     o_bit_tick,
    output logic                     o_mid_tick,
    output logic [$clog2(OVS)-1:0]   o_phase
);

    localparam int unsigned PH_W     = $clog2(OVS);
    localparam int unsigned CW       = DIV_W + 1;
    localparam int unsigned CLK_HZ   = CLK * 1000000;
    localparam int unsigned FRAC_MOD = 1 << FRAC_W;
    localparam int unsigned DEF_INT  = CLK_HZ / (BAUD * OVS);
    localparam int unsigned DEF_FRAC = ((CLK_HZ * FRAC_MOD) / (BAUD * OVS)) % FRAC_MOD;

    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [DIV_W-1:0]  act_int_q, act_int_d;
    logic [FRAC_W-1:0] act_frac_q, act_frac_d;
    logic [DIV_W-1:0]  pend_int_q, pend_int_d;
    logic [FRAC_W-1:0] pend_frac_q, pend_frac_d;
    logic              pend_q, pend_d;
    logic              tick_q, tick_d;
    logic              bit_q, bit_d;
    logic              mid_q, mid_d;
    logic              err_q, err_d;

    logic [FRAC_W:0]   acc_sum_c;
    logic              carry_c;
    logic [CW-1:0]     last_c;
    logic              terminal_c;

    // Interval is act_int cycles, stretched by one whenever the accumulator overflows.
    assign acc_sum_c  = {1'b0, acc_q} + {1'b0, act_frac_q};
    assign carry_c    = acc_sum_c[FRAC_W];
    assign last_c     = {1'b0, act_int_q} - CW'(1) + CW'(carry_c);
    // >= guards against a divisor that shrank while the count was held.
    assign terminal_c = ({1'b0, cnt_q} >= last_c);

    always_comb begin
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        phase_d     = phase_q;
        act_int_d   = act_int_q;
        act_frac_d  = act_frac_q;
        pend_int_d  = pend_int_q;
        pend_frac_d = pend_frac_q;
        pend_d      = pend_q;
        tick_d      = 1'b0;
        bit_d       = 1'b0;
        mid_d       = 1'b0;
        err_d       = 1'b0;

        if (i_clr) begin
            cnt_d   = '0;
            acc_d   = '0;
            phase_d = '0;
            if (pend_q) begin
                act_int_d  = pend_int_q;
                act_frac_d = pend_frac_q;
                pend_d     = 1'b0;
            end
        end else if (i_en) begin
            if (terminal_c) begin
                cnt_d   = '0;
                tick_d  = 1'b1;
                bit_d   = (phase_q == PH_W'(OVS - 1));
                mid_d   = (phase_q == PH_W'(OVS / 2 - 1));
                acc_d   = acc_sum_c[FRAC_W-1:0];
                phase_d = phase_q + PH_W'(1);
                if (pend_q) begin
                    act_int_d  = pend_int_q;
                    act_frac_d = pend_frac_q;
                    pend_d     = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end else if (pend_q) begin
            act_int_d  = pend_int_q;
            act_frac_d = pend_frac_q;
            pend_d     = 1'b0;
        end

        // A write on an activation edge lands in pend after the old pend was consumed.
        if (i_div_wr) begin
            if (i_div_int >= DIV_W'(2)) begin
                pend_int_d  = i_div_int;
                pend_frac_d = i_div_frac;
                pend_d      = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            phase_q     <= '0;
            act_int_q   <= DIV_W'(DEF_INT);
            act_frac_q  <= FRAC_W'(DEF_FRAC);
            pend_int_q  <= '0;
            pend_frac_q <= '0;
            pend_q      <= 1'b0;
            tick_q      <= 1'b0;
            bit_q       <= 1'b0;
            mid_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            phase_q     <= phase_d;
            act_int_q   <= act_int_d;
            act_frac_q  <= act_frac_d;
            pend_int_q  <= pend_int_d;
            pend_frac_q <= pend_frac_d;
            pend_q      <= pend_d;
            tick_q      <= tick_d;
            bit_q       <= bit_d;
            mid_q       <= mid_d;
            err_q       <= err_d;
        end
    end

    assign o_div_busy = pend_q;
    assign o_div_err  = err_q;
    assign o_tick     = tick_q;
    assign o_bit_tick = bit_q;
    assign o_mid_tick = mid_q;
    assign o_phase    = phase_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed bench for baud_tick_gen at default parameters (25-cycle period, OVS=16).
module tb_baud_tick_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        clr;
    logic        div_wr;
    logic [15:0] div_int;
    logic [3:0]  div_frac;
    logic        div_busy;
    logic        div_err;
    logic        tick;
    logic        bit_tick;
    logic        mid_tick;
    logic [3:0]  phase;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    baud_tick_gen dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_en       (en),
        .i_clr      (clr),
        .i_div_wr   (div_wr),
        .i_div_int  (div_int),
        .i_div_frac (div_frac),
        .o_div_busy (div_busy),
        .o_div_err  (div_err),
        .o_tick     (tick),
        .o_bit_tick (bit_tick),
        .o_mid_tick (mid_tick),
        .o_phase    (phase)
    );

    // Counts falling edges until o_tick is seen, bounded by limit.
    task automatic wait_tick(input int limit, output int cycles, output bit ok);
        cycles = 0;
        ok     = 1'b0;
        while (cycles < limit) begin
            @(negedge clk);
            cycles++;
            if (tick) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; div_wr = 1'b0;
        div_int = '0; div_frac = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({tick, bit_tick, mid_tick, div_busy, div_err} !== 5'b0)
            $display("FAIL reset_outputs: got %b want 00000", {tick, bit_tick, mid_tick, div_busy, div_err});
        else n_pass++;
        n_checks++;
        if (phase !== 4'd0) $display("FAIL reset_phase: got %0d want 0", phase);
        else n_pass++;
        rst_n = 1'b1;
        en    = 1'b1;
    endtask

    task automatic test_default();
        int nt, last, bad, first_tick, b1, b2, m1, m2;
        nt = 0; last = 0; bad = 0; first_tick = -1; b1 = -1; b2 = -1; m1 = -1; m2 = -1;
        for (int t = 1; t <= 850; t++) begin
            @(negedge clk);
            if (tick) begin
                nt++;
                if (nt == 1) first_tick = t;
                else if (t - last != 25) bad++;
                last = t;
            end
            if ((bit_tick || mid_tick) && !tick) bad++;
            if (bit_tick) begin if (b1 < 0) b1 = t; else if (b2 < 0) b2 = t; end
            if (mid_tick) begin if (m1 < 0) m1 = t; else if (m2 < 0) m2 = t; end
        end
        n_checks++;
        if (first_tick !== 25) $display("FAIL first_tick: got %0d want 25", first_tick); else n_pass++;
        n_checks++;
        if (bad !== 0) $display("FAIL default_spacing: bad=%0d want 0", bad); else n_pass++;
        n_checks++;
        if (nt !== 34) $display("FAIL default_tick_count: got %0d want 34", nt); else n_pass++;
        n_checks++;
        if (m1 !== 200) $display("FAIL first_mid: got %0d want 200", m1); else n_pass++;
        n_checks++;
        if (b1 !== 400) $display("FAIL first_bit: got %0d want 400", b1); else n_pass++;
        n_checks++;
        if (m2 !== 600) $display("FAIL second_mid: got %0d want 600", m2); else n_pass++;
        n_checks++;
        if (b2 !== 800) $display("FAIL second_bit: got %0d want 800", b2); else n_pass++;
        n_checks++;
        if (phase !== 4'd2) $display("FAIL default_phase: got %0d want 2", phase); else n_pass++;
    endtask

    task automatic test_frac();
        int c, total, exp_c;
        bit ok;
        div_wr = 1'b1; div_int = 16'd54; div_frac = 4'd4;
        @(negedge clk);
        div_wr = 1'b0;
        n_checks++;
        if (div_busy !== 1'b1) $display("FAIL frac_busy_rise: got %b want 1", div_busy); else n_pass++;
        wait_tick(1000, c, ok);
        n_checks++;
        if (!ok || 1 + c !== 25) $display("FAIL frac_old_interval: got %0d want 25", 1 + c); else n_pass++;
        n_checks++;
        if (div_busy !== 1'b0) $display("FAIL frac_busy_fall: got %b want 0", div_busy); else n_pass++;
        total = 0;
        for (int i = 0; i < 16; i++) begin
            wait_tick(1000, c, ok);
            total += c;
            exp_c = (i % 4 == 3) ? 55 : 54;
            n_checks++;
            if (!ok || c !== exp_c) $display("FAIL frac_spacing[%0d]: got %0d want %0d", i, c, exp_c);
            else n_pass++;
        end
        n_checks++;
        if (total !== 868) $display("FAIL frac_total: got %0d want 868", total); else n_pass++;
    endtask

    task automatic test_mid_write();
        int c;
        bit ok;
        repeat (10) @(negedge clk);
        div_wr = 1'b1; div_int = 16'd30; div_frac = 4'd0;
        @(negedge clk);
        div_int = 16'd40;
        @(negedge clk);
        div_wr = 1'b0;
        n_checks++;
        if (div_busy !== 1'b1) $display("FAIL mid_busy: got %b want 1", div_busy); else n_pass++;
        wait_tick(1000, c, ok);
        n_checks++;
        if (!ok || 12 + c !== 54) $display("FAIL mid_old_interval: got %0d want 54", 12 + c); else n_pass++;
        n_checks++;
        if (div_busy !== 1'b0) $display("FAIL mid_busy_fall: got %b want 0", div_busy); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            wait_tick(1000, c, ok);
            n_checks++;
            if (!ok || c !== 40) $display("FAIL mid_last_write_wins[%0d]: got %0d want 40", i, c); else n_pass++;
        end
    endtask

    task automatic test_div_err();
        int c;
        bit ok;
        div_wr = 1'b1; div_int = 16'd1; div_frac = 4'd0;
        @(negedge clk);
        div_wr = 1'b0;
        n_checks++;
        if ({div_err, div_busy} !== 2'b10) $display("FAIL err_pulse: got err,busy=%b want 10", {div_err, div_busy});
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (div_err !== 1'b0) $display("FAIL err_width: got %b want 0", div_err); else n_pass++;
        wait_tick(1000, c, ok);
        n_checks++;
        if (!ok || 2 + c !== 40) $display("FAIL err_spacing: got %0d want 40", 2 + c); else n_pass++;
        div_wr = 1'b1; div_int = 16'd2; div_frac = 4'd0;
        @(negedge clk);
        div_wr = 1'b0;
        n_checks++;
        if (div_busy !== 1'b1) $display("FAIL min_busy: got %b want 1", div_busy); else n_pass++;
        wait_tick(1000, c, ok);
        n_checks++;
        if (!ok || 1 + c !== 40) $display("FAIL min_switch: got %0d want 40", 1 + c); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            wait_tick(1000, c, ok);
            n_checks++;
            if (!ok || c !== 2) $display("FAIL min_spacing[%0d]: got %0d want 2", i, c); else n_pass++;
        end
    endtask

    task automatic test_enable();
        int c, bad;
        bit ok;
        logic [3:0] ph;
        div_wr = 1'b1; div_int = 16'd20; div_frac = 4'd0;
        @(negedge clk);
        div_wr = 1'b0;
        wait_tick(1000, c, ok);
        n_checks++;
        if (!ok || 1 + c !== 2) $display("FAIL en_switch: got %0d want 2", 1 + c); else n_pass++;
        wait_tick(1000, c, ok);
        n_checks++;
        if (!ok || c !== 20) $display("FAIL en_period: got %0d want 20", c); else n_pass++;
        repeat (5) @(negedge clk);
        ph  = phase;
        en  = 1'b0;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (tick || phase !== ph) bad++;
        end
        en = 1'b1;
        n_checks++;
        if (bad !== 0) $display("FAIL en_hold: bad=%0d want 0", bad); else n_pass++;
        wait_tick(1000, c, ok);
        n_checks++;
        if (!ok || c !== 15) $display("FAIL en_resume: got %0d want 15", c); else n_pass++;
        n_checks++;
        if (phase !== ph + 4'd1) $display("FAIL en_phase: got %0d want %0d", phase, ph + 4'd1); else n_pass++;
    endtask

    task automatic test_clear();
        int c;
        bit ok;
        wait_tick(1000, c, ok);
        n_checks++;
        if (!ok || c !== 20) $display("FAIL clr_pre_period: got %0d want 20", c); else n_pass++;
        repeat (7) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        n_checks++;
        if ({phase, tick} !== 5'b0) $display("FAIL clr_state: got phase=%0d tick=%b want 0 0", phase, tick);
        else n_pass++;
        wait_tick(1000, c, ok);
        n_checks++;
        if (!ok || c !== 20) $display("FAIL clr_full_period: got %0d want 20", c); else n_pass++;
        n_checks++;
        if (phase !== 4'd1) $display("FAIL clr_phase_after: got %0d want 1", phase); else n_pass++;
    endtask

    task automatic test_async_reset();
        int c;
        bit ok;
        div_wr = 1'b1; div_int = 16'd50; div_frac = 4'd0;
        @(negedge clk);
        div_wr = 1'b0;
        n_checks++;
        if (div_busy !== 1'b1) $display("FAIL rst_pre_busy: got %b want 1", div_busy); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({phase, div_busy, tick, bit_tick, mid_tick, div_err} !== 9'b0)
            $display("FAIL rst_async: got phase=%0d busy=%b want all 0", phase, div_busy);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wait_tick(1000, c, ok);
            n_checks++;
            if (!ok || c !== 25) $display("FAIL rst_spacing[%0d]: got %0d want 25", i, c); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_default();
        test_frac();
        test_mid_write();
        test_div_err();
        test_enable();
        test_clear();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
